// File: rtl/fix2float_seq_if.sv
// Handshake bundle between a fixed-point producer, the fix2float converter and
// the float consumer. The converter sits on the slave side.
interface fix2float_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fixn;
  logic [4:0]  fixposition;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] floatn;

  modport master (
    output in_valid, fixn, fixposition, out_ready,
    input  in_ready, out_valid, floatn
  );

  modport slave (
    input  in_valid, fixn, fixposition, out_ready,
    output in_ready, out_valid, floatn
  );
endinterface

// File: rtl/fix2float_seq.sv
// Signed fixed-point to IEEE-754 single converter: one normalising shift per
// cycle, a single rounding step, then the result is held under valid/ready.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shifting magnitude left until bit 31 is set
// ROUND | round mantissa, pack float
// DONE  | result presented, out_valid high until out_ready
module fix2float_seq #(
  parameter int ROUND_MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  fix2float_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] floatn_q, floatn_d;

  logic        rnd_inc;
  logic [23:0] mant_sum;
  logic [7:0]  exp_rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      floatn_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      floatn_q <= floatn_d;
    end
  end

  // Mantissa carry-out leaves sum[22:0] at zero, so bumping the exponent is enough.
  always_comb begin
    rnd_inc  = (ROUND_MODE != 0) && mag_q[7] && ((|mag_q[6:0]) || mag_q[8]);
    mant_sum = {1'b0, mag_q[30:8]} + {23'b0, rnd_inc};
    exp_rnd  = exp_q + {7'b0, mant_sum[23]};
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    floatn_d = floatn_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.fixn[31];
          mag_d  = bus.fixn[31] ? (~bus.fixn + 32'd1) : bus.fixn;
          exp_d  = 8'd158 - {3'b000, bus.fixposition};
          if (bus.fixn == 32'd0) begin
            floatn_d = 32'd0;
            state_d  = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      ROUND: begin
        exp_d    = exp_rnd;
        floatn_d = {sign_q, exp_rnd, mant_sum[22:0]};
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.floatn    = floatn_q;

endmodule

// File: tb/tb_fix2float_seq.sv
// Self-checking bench for fix2float_seq: directed corner cases, reset abort and
// random operands against an arithmetic reference of the conversion.
module tb_fix2float_seq;
  localparam int RM = 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  fix2float_seq_if bus ();

  fix2float_seq #(.ROUND_MODE(RM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: locate the leading one, split off mantissa and discarded bits,
  // round to nearest-even on the discarded value.
  function automatic int msb_pos(input logic [31:0] x);
    logic [31:0] m;
    int p;
    m = x[31] ? (32'd0 - x) : x;
    p = 31;
    while (p > 0 && !m[p]) p--;
    return p;
  endfunction

  function automatic logic [31:0] ref_float(input logic [31:0] x, input int fp);
    longint unsigned m, mant, rem, half;
    int p, sh, e;
    if (x == 32'd0) return 32'd0;
    m = x[31] ? longint'(32'd0 - x) : longint'(x);
    p = msb_pos(x);
    e = 127 + p - fp;
    if (p >= 23) begin
      sh   = p - 23;
      mant = (m >> sh) & 64'h7F_FFFF;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = (sh > 0) ? (64'd1 << (sh - 1)) : 64'd0;
      if (RM != 0 && sh > 0 && (rem > half || (rem == half && mant[0]))) mant++;
      if (mant == 64'h80_0000) begin
        mant = 0;
        e++;
      end
    end else begin
      mant = (m << (23 - p)) & 64'h7F_FFFF;
    end
    return {x[31], e[7:0], mant[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    if (x == 32'd0) return 1;
    return (31 - msb_pos(x)) + 3;
  endfunction

  // Accept one operand, time the result, hold it for 'hold' cycles, then release.
  task automatic convert(input logic [31:0] x, input logic [4:0] fp, input int hold,
                         input logic [31:0] exp_f, input int exp_lat, input string tag);
    int cyc;
    chk({tag, "_in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.fixn        = x;
    bus.fixposition = fp;
    bus.out_ready   = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      bus.in_valid = 1'b0;
      bus.fixn     = $urandom;
    end while (!bus.out_valid && cyc < 80);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_floatn"}, bus.floatn, exp_f);
    chk({tag, "_in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid    = 1'b1;
      bus.fixn        = $urandom;
      bus.fixposition = 5'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_floatn"}, bus.floatn, exp_f);
      chk({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_release_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_release_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_retain_floatn"}, bus.floatn, exp_f);
  endtask

  initial begin
    logic [31:0] x;
    logic [4:0]  fp;
    int          seen;

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.fixn        = '0;
    bus.fixposition = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_floatn", bus.floatn, 32'd0);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    convert(32'hFFFF_FFF9, 5'd0, 0, 32'hC0E0_0000, 32, "neg7");
    convert(32'h0000_0000, 5'd17, 1, 32'h0000_0000, 1, "zero");
    convert(32'h8000_0000, 5'd0, 0, 32'hCF00_0000, 3, "minint");
    convert(32'h7FFF_FFFF, 5'd0, 0, (RM != 0) ? 32'h4F00_0000 : 32'h4EFF_FFFF, 4, "maxint");
    convert(32'h0000_0001, 5'd31, 0, 32'h3000_0000, 34, "tiny");
    convert(32'h0000_0003, 5'd1, 5, 32'h3FC0_0000, 33, "hold5");

    // Reset while normalising: operation must vanish.
    bus.in_valid    = 1'b1;
    bus.fixn        = 32'hFFFF_FFF9;
    bus.fixposition = 5'd0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    convert(32'hFFFF_FFF9, 5'd0, 0, 32'hC0E0_0000, 32, "neg7_again");

    for (int n = 0; n < 40; n++) begin
      x  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = 32'd0 - x;
      if (n == 7) x = 32'd0;
      fp = 5'($urandom);
      convert(x, fp, $urandom_range(0, 3), ref_float(x, int'(fp)), ref_lat(x), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
